usbfs_pkt_tx: RTL and testbench

//  Full Speed USB packet transmitter: design counterpart of usbfsPktRx, same 48MHz domain.

---
 rtl/usbfs_pkt_tx.sv | 181 ++++++++++++++++++
 tb/tb_usbfs_pkt_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbfs_pkt_tx.sv
// Full Speed USB packet transmitter: serialises SYNC, PID, payload and CRC with
// bit stuffing and NRZI, then drives SE0/J end-of-packet on dp/dn.
module usbfs_pkt_tx #(
  parameter int MAX_PKT = 8
) (
  input  logic                       i_clk_48MHz,
  input  logic                       i_rst,
  output logic                       o_ready,
  input  logic                       i_valid,
  input  logic [3:0]                 i_pid,
  input  logic [8*MAX_PKT-1:0]       i_data,
  input  logic [$clog2(MAX_PKT):0]   i_data_nBytes,
  output logic                       o_dp,
  output logic                       o_dn,
  output logic                       o_oe,
  output logic                       o_inflight,
  output logic                       o_eopDone,
  output logic [3:0]                 dbg_state
);
  localparam int NW = $clog2(MAX_PKT) + 1;
  localparam int IW = NW + 3;
  localparam logic [NW-1:0] MAX_N = NW'(MAX_PKT);
  localparam logic [IW-1:0] ONE_I = IW'(1);

  // Handshake: a packet is accepted on any cycle with i_valid && o_ready;
  // o_ready stays low from the accept until the cycle after o_eopDone.

  // state names the next item to put on the bus, not the one being driven
  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16, S_SE0, S_EOPJ, S_DONE
  } state_t;

  state_t               state, state_n;
  logic [IW-1:0]        idx, idx_n;
  logic [1:0]           ph, ph_n;
  logic [2:0]           ones, ones_n;
  logic [3:0]           pid_q, pid_n;
  logic [8*MAX_PKT-1:0] data_q, data_n;
  logic [IW-1:0]        nbits_q, nbits_n;
  logic [4:0]           crc5, crc5_n;
  logic [15:0]          crc16, crc16_n;
  logic                 j_q, j_n;
  logic                 se0_q, se0_n;
  logic                 inflight_q, inflight_n;
  logic                 cur_bit, fb5, fb16;
  logic [7:0]           pid_byte;
  logic [NW-1:0]        n_clamped;

  always_ff @(posedge i_clk_48MHz) begin
    if (i_rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      ph         <= '0;
      ones       <= '0;
      pid_q      <= '0;
      data_q     <= '0;
      nbits_q    <= '0;
      crc5       <= 5'h1F;
      crc16      <= 16'hFFFF;
      j_q        <= 1'b1;
      se0_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      ph         <= ph_n;
      ones       <= ones_n;
      pid_q      <= pid_n;
      data_q     <= data_n;
      nbits_q    <= nbits_n;
      crc5       <= crc5_n;
      crc16      <= crc16_n;
      j_q        <= j_n;
      se0_q      <= se0_n;
      inflight_q <= inflight_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    ph_n       = ph;
    ones_n     = ones;
    pid_n      = pid_q;
    data_n     = data_q;
    nbits_n    = nbits_q;
    crc5_n     = crc5;
    crc16_n    = crc16;
    j_n        = j_q;
    se0_n      = se0_q;
    inflight_n = inflight_q;
    pid_byte   = {~pid_q, pid_q};
    n_clamped  = (i_data_nBytes > MAX_N) ? MAX_N : i_data_nBytes;

    case (state)
      S_SYNC:  cur_bit = (idx == IW'(7));
      S_PID:   cur_bit = pid_byte[idx[2:0]];
      S_TOKEN: cur_bit = data_q[idx[IW-2:0]];
      S_CRC5:  cur_bit = ~crc5[3'd4 - idx[2:0]];
      S_DATA:  cur_bit = data_q[idx[IW-2:0]];
      S_CRC16: cur_bit = ~crc16[4'd15 - idx[3:0]];
      default: cur_bit = 1'b0;
    endcase
    fb5  = crc5[4] ^ cur_bit;
    fb16 = crc16[15] ^ cur_bit;

    if (!inflight_q) begin
      if (i_valid) begin
        // the first SYNC bit (logical 0 -> K) goes out together with the capture
        pid_n      = i_pid;
        data_n     = i_data;
        nbits_n    = {n_clamped, 3'b000};
        state_n    = S_SYNC;
        idx_n      = ONE_I;
        ph_n       = 2'd0;
        ones_n     = 3'd0;
        crc5_n     = 5'h1F;
        crc16_n    = 16'hFFFF;
        j_n        = 1'b0;
        se0_n      = 1'b0;
        inflight_n = 1'b1;
      end
    end else begin
      ph_n = ph + 2'd1;
      if (ph == 2'd3) begin
        if (state == S_DONE) begin
          inflight_n = 1'b0;
          state_n    = S_IDLE;
          ph_n       = 2'd0;
        end else if (state == S_EOPJ) begin
          se0_n   = 1'b0;
          j_n     = 1'b1;
          state_n = S_DONE;
        end else if (ones == 3'd6) begin
          // stuffed 0: toggle the line, keep the cursor where it is
          j_n    = ~j_q;
          ones_n = 3'd0;
        end else if (state == S_SE0) begin
          se0_n  = 1'b1;
          ones_n = 3'd0;
          if (idx == ONE_I) begin
            state_n = S_EOPJ;
            idx_n   = '0;
          end else begin
            idx_n = idx + ONE_I;
          end
        end else begin
          if (!cur_bit) j_n = ~j_q;
          ones_n = (state == S_SYNC || !cur_bit) ? 3'd0 : ones + 3'd1;
          if (state == S_TOKEN) crc5_n  = {crc5[3:0], 1'b0} ^ (fb5 ? 5'h05 : 5'h00);
          if (state == S_DATA)  crc16_n = {crc16[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
          idx_n = idx + ONE_I;
          case (state)
            S_SYNC:  if (idx == IW'(7)) begin state_n = S_PID; idx_n = '0; end
            S_PID: begin
              if (idx == IW'(7)) begin
                idx_n = '0;
                if (pid_q[1:0] == 2'b01 || pid_q == 4'b0100) state_n = S_TOKEN;
                else if (pid_q[1:0] == 2'b11) state_n = (nbits_q == '0) ? S_CRC16 : S_DATA;
                else state_n = S_SE0;
              end
            end
            S_TOKEN: if (idx == IW'(10)) begin state_n = S_CRC5; idx_n = '0; end
            S_CRC5:  if (idx == IW'(4)) begin state_n = S_SE0; idx_n = '0; end
            S_DATA:  if (idx == nbits_q - ONE_I) begin state_n = S_CRC16; idx_n = '0; end
            S_CRC16: if (idx == IW'(15)) begin state_n = S_SE0; idx_n = '0; end
            default: state_n = state;
          endcase
        end
      end
    end
  end

  assign o_ready    = !inflight_q;
  assign o_oe       = inflight_q;
  assign o_inflight = inflight_q;
  assign o_dp       = se0_q ? 1'b0 : j_q;
  assign o_dn       = se0_q ? 1'b0 : ~j_q;
  assign o_eopDone  = inflight_q && (state == S_DONE) && (ph == 2'd3);
  assign dbg_state  = state;
endmodule

// File: tb/tb_usbfs_pkt_tx.sv
// Bench for usbfs_pkt_tx: a bus decoder (NRZI, unstuffing, EOP shape) feeds a
// scoreboard of expected packet bytes pushed when each packet is requested.
module tb_usbfs_pkt_tx;
  localparam int MAX_PKT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready, valid;
  logic [3:0]  pid;
  logic [63:0] data;
  logic [3:0]  nbytes;
  logic        dp, dn, oe, inflight, eop_done;
  logic [3:0]  dbg_state;

  usbfs_pkt_tx #(.MAX_PKT(MAX_PKT)) dut (
    .i_clk_48MHz(clk), .i_rst(rst), .o_ready(ready), .i_valid(valid),
    .i_pid(pid), .i_data(data), .i_data_nBytes(nbytes),
    .o_dp(dp), .o_dn(dn), .o_oe(oe), .o_inflight(inflight),
    .o_eopDone(eop_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  int         exp_stuff_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reflected (LSB-first) CRC16, returned already complemented
  function automatic logic [15:0] crc16_ref(input logic [63:0] d, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {8'h00, d[8*i +: 8]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic expect_pkt(input logic [7:0] b[16], input int len);
    int ones = 0;
    int st = 0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(b[i]);
      for (int k = 0; k < 8; k++) begin
        if (ones == 6) begin st++; ones = 0; end
        ones = b[i][k] ? ones + 1 : 0;
      end
    end
    if (ones == 6) st++;
    exp_len_q.push_back(len);
    exp_stuff_q.push_back(st);
  endtask

  task automatic expect_data(input logic [3:0] p, input logic [63:0] d, input int n);
    logic [7:0]  b[16];
    logic [15:0] c;
    c = crc16_ref(d, n);
    b[0] = {~p, p};
    for (int i = 0; i < n; i++) b[i+1] = d[8*i +: 8];
    b[n+1] = c[7:0];
    b[n+2] = c[15:8];
    expect_pkt(b, n + 3);
  endtask

  // ---------------- bus monitor / scoreboard ----------------
  int         pkts = 0, aborts = 0;
  int         last_start, last_eop, prev_eop, last_stuffs;
  logic       m_active = 1'b0;
  int         m_cyc, m_start, m_stage, m_nbits, m_ones, m_bitcnt, m_se0, m_stuffs;
  int         m_hold_err, m_stuff_err, m_bad, m_eop_err, m_len;
  logic [1:0] m_cur, sym;
  logic       m_prev, jlev, b, exp_eop;
  logic [7:0] m_sync, m_byte, e, g;
  logic [7:0] m_got_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!m_active && oe === 1'b1) begin
        m_active = 1'b1; m_cyc = 0; m_start = cyc_g; m_stage = 0; m_nbits = 0;
        m_ones = 0; m_bitcnt = 0; m_se0 = 0; m_stuffs = 0; m_hold_err = 0;
        m_stuff_err = 0; m_bad = 0; m_eop_err = 0; m_prev = 1'b1; m_got_q.delete();
      end
      if (m_active) begin
        if (oe !== 1'b1) begin
          m_active = 1'b0;
          aborts++;
        end else begin
          sym = {dp, dn};
          if (m_cyc % 4 == 0) begin
            m_cur = sym;
            case (sym)
              2'b00: begin
                if (m_stage == 2) m_bad++;
                m_stage = 1;
                m_se0++;
              end
              2'b10, 2'b01: begin
                jlev = (sym == 2'b10);
                if (m_stage == 1) begin
                  if (jlev) m_stage = 2; else m_bad++;
                end else if (m_stage == 2) begin
                  m_bad++;
                end else begin
                  b = (jlev == m_prev);
                  m_prev = jlev;
                  if (m_nbits < 8) begin
                    m_sync[m_nbits] = b;
                    m_nbits++;
                  end else if (m_ones == 6) begin
                    m_stuffs++;
                    if (b) m_stuff_err++;
                    m_ones = 0;
                  end else begin
                    m_ones = b ? m_ones + 1 : 0;
                    m_byte[m_bitcnt % 8] = b;
                    m_bitcnt++;
                    if (m_bitcnt % 8 == 0) m_got_q.push_back(m_byte);
                  end
                end
              end
              default: m_bad++;
            endcase
          end else if (sym !== m_cur) begin
            m_hold_err++;
          end
          exp_eop = (m_stage == 2) && (m_cyc % 4 == 3);
          if (eop_done !== exp_eop) m_eop_err++;
          if (exp_eop && eop_done === 1'b1) begin
            check("sync_pattern", m_sync, 8'h80);
            check("se0_bits", m_se0, 2);
            check("symbol_hold", m_hold_err, 0);
            check("eop_pulse", m_eop_err, 0);
            check("bad_symbol", m_bad, 0);
            check("stuff_bit_value", m_stuff_err, 0);
            check("whole_bytes", m_bitcnt % 8, 0);
            check("expected_pending", exp_len_q.size() > 0, 1);
            if (exp_len_q.size() > 0) begin
              m_len = exp_len_q.pop_front();
              check("pkt_len", m_got_q.size(), m_len);
              for (int i = 0; i < m_len; i++) begin
                e = exp_q.pop_front();
                g = (i < m_got_q.size()) ? m_got_q[i] : 8'hxx;
                check($sformatf("pkt%0d_byte%0d", pkts, i), g, e);
              end
              check("stuff_count", m_stuffs, exp_stuff_q.pop_front());
            end
            prev_eop    = last_eop;
            last_start  = m_start;
            last_eop    = cyc_g;
            last_stuffs = m_stuffs;
            pkts++;
            m_active = 1'b0;
          end
          m_cyc++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] p, input logic [63:0] d, input logic [3:0] n);
    int k = 0;
    @(negedge clk);
    while (ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_send", ready, 1'b1);
    valid = 1'b1; pid = p; data = d; nbytes = n;
    @(negedge clk);
    valid = 1'b0; pid = $urandom_range(15, 0); data = {$urandom, $urandom}; nbytes = 4'd0;
  endtask

  task automatic wait_pkts(input int target);
    int k = 0;
    while (pkts < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("pkt_done_in_time", pkts >= target, 1);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0]  bb[16];
  logic [63:0] rnd_d;
  int          rnd_n;

  initial begin
    rst = 1'b1; valid = 1'b0; pid = 4'd0; data = '0; nbytes = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_oe", oe, 1'b0);
    check("rst_line_j", {dp, dn}, 2'b10);
    check("rst_inflight", inflight, 1'b0);
    check("rst_eop_done", eop_done, 1'b0);
    check("rst_state", dbg_state, 4'd0);
    rst = 1'b0;

    // ACK: PID only, exactly 19 bit times on the bus
    bb[0] = 8'hD2; expect_pkt(bb, 1);
    send(4'b0010, 64'd0, 4'd0);
    check("first_k_oe", oe, 1'b1);
    check("first_k_line", {dp, dn}, 2'b01);
    check("first_k_inflight", inflight, 1'b1);
    check("busy_not_ready", ready, 1'b0);
    wait_pkts(1);
    check("ack_cycles", last_eop - last_start, 75);
    @(negedge clk);
    check("idle_after_ack", {oe, ready, dp, dn}, 4'b0110);

    // SETUP to addr 0 endp 0, with a request attempted mid-packet
    bb[0] = 8'h2D; bb[1] = 8'h00; bb[2] = 8'h10; expect_pkt(bb, 3);
    send(4'b1101, 64'd0, 4'd0);
    repeat (20) @(negedge clk);
    check("valid_while_busy_ready", ready, 1'b0);
    valid = 1'b1; pid = 4'b0010;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    wait_pkts(2);
    repeat (10) @(negedge clk);
    check("no_extra_pkt_oe", oe, 1'b0);

    // DATA0 GET_DESCRIPTOR setup payload, then same with length over MAX_PKT
    for (int r = 0; r < 2; r++) begin
      bb[0] = 8'hC3; bb[1] = 8'h80; bb[2] = 8'h06; bb[3] = 8'h00; bb[4] = 8'h01;
      bb[5] = 8'h00; bb[6] = 8'h00; bb[7] = 8'h40; bb[8] = 8'h00;
      bb[9] = 8'hDD; bb[10] = 8'h94;
      expect_pkt(bb, 11);
      send(4'b0011, 64'h0040_0000_0100_0680, (r == 0) ? 4'd8 : 4'd15);
      wait_pkts(3 + r);
    end

    // DATA1 FF FF: long runs of ones force stuffing
    expect_data(4'b1011, 64'h0000_0000_0000_FFFF, 2);
    send(4'b1011, 64'h0000_0000_0000_FFFF, 4'd2);
    wait_pkts(5);
    check("ff_stuffs_at_least_two", last_stuffs >= 2, 1);

    // zero-length DATA0 followed back-to-back by ACK
    bb[0] = 8'hC3; bb[1] = 8'h00; bb[2] = 8'h00; expect_pkt(bb, 3);
    send(4'b0011, 64'd0, 4'd0);
    bb[0] = 8'hD2; expect_pkt(bb, 1);
    send(4'b0010, 64'd0, 4'd0);
    wait_pkts(7);
    check("back_to_back_gap", last_start - prev_eop, 2);

    // reset in the middle of a DATA payload
    send(4'b0011, 64'h0040_0000_0100_0680, 4'd8);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_line_j", {dp, dn}, 2'b10);
    check("midrst_oe", oe, 1'b0);
    check("midrst_ready", ready, 1'b1);
    check("midrst_inflight", inflight, 1'b0);
    expect_data(4'b0011, 64'h0040_0000_0100_0680, 8);
    send(4'b0011, 64'h0040_0000_0100_0680, 4'd8);
    wait_pkts(8);

    // random DATA1 payload
    rnd_n = $urandom_range(8, 1);
    rnd_d = {$urandom, $urandom};
    expect_data(4'b1011, rnd_d, rnd_n);
    send(4'b1011, rnd_d, 4'(rnd_n));
    wait_pkts(9);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_len_q.size(), 0);
    check("abort_count", aborts, 1);
    check("total_pkts", pkts, 9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
